// File: rtl/popcount_serial.sv
// Serial Hamming-weight engine: one CHUNK_WIDTH slice per cycle through a shared adder tree.
// Optional macro POPCOUNT_SERIAL_EARLY_EXIT_EN finishes as soon as the remaining bits are all zero.
module popcount_serial #(
    parameter int DATA_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 32,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_W-1:0]      popcount_o,
    output logic                  busy_o
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int TREE_W     = $clog2(CHUNK_WIDTH) + 1;
    localparam int LEAVES     = 1 << $clog2(CHUNK_WIDTH);

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || CHUNK_WIDTH < 2) begin : g_param_check
        $error("popcount_serial: DATA_WIDTH must be a multiple of CHUNK_WIDTH, CHUNK_WIDTH >= 2");
    end

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [TREE_W-1:0]     chunk_pop;
    logic                  last_chunk;

    // Heap-ordered balanced tree: node i sums children 2i+1 and 2i+2; leaves padded to a power of two.
    logic [TREE_W-1:0] node [2*LEAVES-1];

    for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
        if (gi < CHUNK_WIDTH) begin : g_bit
            assign node[LEAVES-1+gi] = TREE_W'(shift_q[gi]);
        end else begin : g_pad
            assign node[LEAVES-1+gi] = '0;
        end
    end

    for (genvar gi = 0; gi < LEAVES-1; gi++) begin : g_node
        assign node[gi] = node[2*gi+1] + node[2*gi+2];
    end

    assign chunk_pop = node[0];
    assign shift_nxt = shift_q >> CHUNK_WIDTH;

`ifdef POPCOUNT_SERIAL_EARLY_EXIT_EN
    assign last_chunk = (cnt_q == IDX_W'(NUM_CHUNKS-1)) || (shift_nxt == '0);
`else
    assign last_chunk = (cnt_q == IDX_W'(NUM_CHUNKS-1));
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    shift_d = data_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                acc_d   = acc_q + CNT_W'(chunk_pop);
                shift_d = shift_nxt;
                cnt_d   = cnt_q + IDX_W'(1);
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                ready_o = ready_i;
                // A new word can enter in the same cycle the result leaves.
                if (ready_i) begin
                    if (valid_i) begin
                        shift_d = data_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = COUNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign popcount_o = acc_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_popcount_serial.sv
// Directed and post-reset random checks for popcount_serial at 256/32.
module tb_popcount_serial;

    localparam int DW = 256;
    localparam int CW = 32;
    localparam int NC = DW / CW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [8:0]    popcount_o;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    popcount_serial #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .popcount_o (popcount_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Cycles from accept to valid_o: fixed, or up to the highest non-zero chunk with early exit.
    function automatic int exp_lat(input logic [DW-1:0] d);
        int lat;
        lat = NC;
`ifdef POPCOUNT_SERIAL_EARLY_EXIT_EN
        lat = 1;
        for (int c = 0; c < NC; c++) begin
            if (((d >> (c*CW)) & {{(DW-CW){1'b0}}, {CW{1'b1}}}) != '0) lat = c + 1;
        end
`endif
        return lat;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Counts edges until valid_o rises, bounded.
    task automatic wait_result(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!valid_o && cycles < 40);
    endtask

    task automatic accept(input logic [DW-1:0] d, input string tag);
        check({tag, " ready_o before accept"}, ready_o, 1);
        valid_i = 1'b1;
        data_i  = d;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic run_word(input logic [DW-1:0] d, input int pop, input string tag);
        int cyc;
        accept(d, tag);
        wait_result(cyc);
        check({tag, " latency"}, cyc, exp_lat(d));
        check({tag, " popcount"}, popcount_o, pop);
        tick();
        check({tag, " valid_o one cycle"}, valid_o, 0);
        check({tag, " back to idle"}, busy_o, 0);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [8:0]    held;
        logic [DW-1:0] rnd;

        #2;
        check("reset valid_o", valid_o, 0);
        check("reset ready_o", ready_o, 1);
        check("reset busy_o", busy_o, 0);
        check("reset popcount_o", popcount_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        run_word({DW{1'b1}}, 256, "all_ones");
        run_word({DW{1'b0}}, 0, "all_zeros");
        run_word({1'b1, {(DW-1){1'b0}}}, 1, "msb_only");
        run_word({{(DW-32){1'b0}}, 32'hFFFF_FFFF}, 32, "low_chunk");
        run_word({{(DW-8){1'b0}}, 8'h81}, 2, "low_two_bits");

        // Backpressure in DONE
        ready_i = 1'b0;
        accept({8{32'h0000_0003}}, "bp");
        wait_result(cyc);
        check("bp latency", cyc, NC);
        held = popcount_o;
        check("bp popcount", held, 16);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp valid_o held", valid_o, 1);
            check("bp popcount stable", popcount_o, 16);
            check("bp ready_o low", ready_o, 0);
        end
        ready_i = 1'b1;
        #1;
        check("bp ready_o follows ready_i", ready_o, 1);
        tick();
        check("bp handoff valid_o", valid_o, 0);
        check("bp handoff idle", busy_o, 0);

        // Back-to-back with valid_i held
        valid_i = 1'b1;
        data_i  = {64{4'hA}};
        tick();
        wait_result(cyc);
        check("b2b first latency", cyc, NC);
        check("b2b first popcount", popcount_o, 128);
        data_i = {32{8'h0F}};
        #1;
        check("b2b ready_o at handoff", ready_o, 1);
        tick();
        valid_i = 1'b0;
        check("b2b second accepted valid_o", valid_o, 0);
        check("b2b second accepted busy_o", busy_o, 1);
        wait_result(cyc);
        check("b2b second latency", cyc, NC);
        check("b2b second popcount", popcount_o, 128);
        tick();
        check("b2b done idle", busy_o, 0);

        // Reset during COUNT cycle 4
        accept({DW{1'b1}}, "rst");
        for (int i = 0; i < 3; i++) tick();
        check("rst busy before reset", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("rst valid_o", valid_o, 0);
        check("rst busy_o", busy_o, 0);
        check("rst ready_o", ready_o, 1);
        tick();
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o) seen++;
        end
        check("rst no result emitted", seen, 0);

        // Random words against a reference count
        for (int n = 0; n < 6; n++) begin
            for (int w = 0; w < NC; w++) rnd[w*32 +: 32] = $urandom;
            if (n == 5) rnd[DW-1 -: 64] = '0;
            run_word(rnd, $countones(rnd), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
